// File: rtl/jtag_shift_engine.sv
// JTAG bit-shift engine: shifts up to C_VECTOR_WIDTH TMS/TDI bits per command at a
// programmable TCK rate, captures TDO LSB-first and returns it as a response.
module jtag_shift_engine #(
    parameter int C_VECTOR_WIDTH = 32,
    parameter int C_LEN_WIDTH    = 6,
    parameter int C_DIV_WIDTH    = 8
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [C_DIV_WIDTH-1:0]    TCK_HALF_DIV,
    input  logic                      CMD_VALID,
    output logic                      CMD_READY,
    input  logic [C_LEN_WIDTH-1:0]    CMD_LEN,
    input  logic [C_VECTOR_WIDTH-1:0] CMD_TMS,
    input  logic [C_VECTOR_WIDTH-1:0] CMD_TDI,
    output logic                      RSP_VALID,
    input  logic                      RSP_READY,
    output logic [C_VECTOR_WIDTH-1:0] RSP_TDO,
    output logic [C_LEN_WIDTH-1:0]    RSP_LEN,
    output logic                      BUSY,
    output logic                      TCK,
    output logic                      TMS,
    output logic                      TDI,
    input  logic                      TDO
);

    localparam logic [C_LEN_WIDTH-1:0] MAX_LEN = C_LEN_WIDTH'(C_VECTOR_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TCKL = 2'd1,
        TCKH = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state, state_n;

    logic [C_VECTOR_WIDTH-1:0] tms_sh, tdi_sh;
    logic [C_LEN_WIDTH-1:0]    len_q, bit_idx, len_clamped;
    logic [C_DIV_WIDTH-1:0]    div_q, cnt;
    logic                      accept, rise, fall, last_bit;

    assign len_clamped = (CMD_LEN > MAX_LEN) ? MAX_LEN : CMD_LEN;
    assign last_bit    = (bit_idx == len_q - C_LEN_WIDTH'(1));

    assign CMD_READY = (state == IDLE);
    assign BUSY      = (state != IDLE);
    assign RSP_VALID = (state == RESP);

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        rise    = 1'b0;
        fall    = 1'b0;
        case (state)
            IDLE: begin
                if (CMD_VALID) begin
                    accept  = 1'b1;
                    state_n = (len_clamped == '0) ? RESP : TCKL;
                end
            end
            TCKL: begin
                if (cnt == '0) begin
                    rise    = 1'b1;
                    state_n = TCKH;
                end
            end
            TCKH: begin
                if (cnt == '0) begin
                    fall    = 1'b1;
                    state_n = last_bit ? RESP : TCKL;
                end
            end
            RESP: begin
                if (RSP_READY) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tms_sh  <= '0;
            tdi_sh  <= '0;
            len_q   <= '0;
            bit_idx <= '0;
            div_q   <= '0;
            cnt     <= '0;
            RSP_TDO <= '0;
            RSP_LEN <= '0;
            TCK     <= 1'b0;
            TMS     <= 1'b0;
            TDI     <= 1'b0;
        end else begin
            if (accept) begin
                tms_sh  <= CMD_TMS >> 1;
                tdi_sh  <= CMD_TDI >> 1;
                len_q   <= len_clamped;
                div_q   <= TCK_HALF_DIV;
                cnt     <= TCK_HALF_DIV;
                bit_idx <= '0;
                RSP_TDO <= '0;
                // A zero-length command must not disturb the TAP, so pins keep their value.
                if (len_clamped != '0) begin
                    TMS <= CMD_TMS[0];
                    TDI <= CMD_TDI[0];
                end else begin
                    RSP_LEN <= '0;
                end
            end else if (state == TCKL || state == TCKH) begin
                cnt <= (cnt == '0) ? div_q : cnt - C_DIV_WIDTH'(1);
            end

            if (rise) begin
                TCK     <= 1'b1;
                RSP_TDO <= RSP_TDO | ({{(C_VECTOR_WIDTH-1){1'b0}}, TDO} << bit_idx);
            end

            if (fall) begin
                TCK <= 1'b0;
                if (last_bit) begin
                    RSP_LEN <= len_q;
                end else begin
                    bit_idx <= bit_idx + C_LEN_WIDTH'(1);
                    TMS     <= tms_sh[0];
                    TDI     <= tdi_sh[0];
                    tms_sh  <= tms_sh >> 1;
                    tdi_sh  <= tdi_sh >> 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Scoreboard bench for jtag_shift_engine: the driver pushes expected responses derived
// from the command semantics, a monitor pops and compares whenever RSP_VALID appears.
module tb_jtag_shift_engine;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [7:0]  TCK_HALF_DIV = '0;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [5:0]  CMD_LEN = '0;
    logic [31:0] CMD_TMS = '0, CMD_TDI = '0;
    logic        RSP_VALID;
    logic        RSP_READY = 1'b0;
    logic [31:0] RSP_TDO;
    logic [5:0]  RSP_LEN;
    logic        BUSY, TCK, TMS, TDI, TDO;

    jtag_shift_engine dut (
        .CLK(CLK), .RESET(RESET), .TCK_HALF_DIV(TCK_HALF_DIV),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_LEN(CMD_LEN),
        .CMD_TMS(CMD_TMS), .CMD_TDI(CMD_TDI), .RSP_VALID(RSP_VALID),
        .RSP_READY(RSP_READY), .RSP_TDO(RSP_TDO), .RSP_LEN(RSP_LEN),
        .BUSY(BUSY), .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] tdo, tms, tdi;
        int          len, vcyc, base, hold;
        logic        ltms, ltdi;
    } exp_t;

    exp_t exp_q[$];
    int total = 0, bad = 0;
    int cyc = 0;
    int tck_total = 0;
    int last_hs = -100;
    logic obs_tms [16384];
    logic obs_tdi [16384];

    // Target device model: presents bit k of cur_tgt after k TCK rising edges.
    logic [31:0] cur_tgt = '0;
    logic        cur_loop = 1'b0;
    int          cur_base = 0;
    logic [31:0] tgt_sh;
    assign tgt_sh = cur_tgt >> (tck_total - cur_base);
    assign TDO = cur_loop ? TDI : tgt_sh[0];

    logic model_tms = 1'b0, model_tdi = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge TCK) begin
        obs_tms[tck_total % 16384] = TMS;
        obs_tdi[tck_total % 16384] = TDI;
        tck_total = tck_total + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] msk(input int l);
        logic [63:0] m;
        m = (64'd1 << l) - 64'd1;
        return m[31:0];
    endfunction

    task automatic send(input int len, input logic [31:0] tms, input logic [31:0] tdi,
                        input int div, input int post_div, input logic [31:0] tgt,
                        input logic loop, input int hold, input bit push, output int acc);
        int   n, l, d;
        exp_t e;
        @(negedge CLK);
        CMD_LEN      = 6'(len);
        CMD_TMS      = tms;
        CMD_TDI      = tdi;
        TCK_HALF_DIV = 8'(div);
        CMD_VALID    = 1'b1;
        n = 0;
        while (!CMD_READY && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        if (!CMD_READY) begin
            chk("cmd_ready_timeout", 1'b0, 1'b1);
            CMD_VALID = 1'b0;
            acc = -1;
            return;
        end
        l = (len > 32) ? 32 : len;
        d = div + 1;
        cur_tgt  = tgt;
        cur_loop = loop;
        cur_base = tck_total;
        acc      = cyc + 1;
        if (push) begin
            e.tdo  = (loop ? tdi : tgt) & msk(l);
            e.tms  = tms & msk(l);
            e.tdi  = tdi & msk(l);
            e.len  = l;
            e.vcyc = cyc + 1 + 2 * d * l;
            e.base = cur_base;
            e.hold = hold;
            if (l > 0) begin
                model_tms = tms[l-1];
                model_tdi = tdi[l-1];
            end
            e.ltms = model_tms;
            e.ltdi = model_tdi;
            exp_q.push_back(e);
        end
        @(negedge CLK);
        CMD_VALID    = 1'b0;
        CMD_LEN      = 6'($urandom);
        TCK_HALF_DIV = 8'(post_div);
    endtask

    // Monitor: pops an expectation at the first cycle of each response.
    initial begin : monitor
        exp_t        e;
        int          pulses;
        logic [31:0] otms, otdi;
        forever begin
            @(negedge CLK);
            if (RSP_VALID) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1'b1, 1'b0);
                    e.hold = 0;
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_tdo", RSP_TDO, e.tdo);
                    chk("rsp_len", RSP_LEN, e.len);
                    chk("rsp_cycle", cyc, e.vcyc);
                    pulses = tck_total - e.base;
                    chk("tck_pulses", pulses, e.len);
                    otms = '0;
                    otdi = '0;
                    for (int i = 0; i < pulses && i < 32; i++) begin
                        otms[i] = obs_tms[(e.base + i) % 16384];
                        otdi[i] = obs_tdi[(e.base + i) % 16384];
                    end
                    chk("tms_bits", otms, e.tms);
                    chk("tdi_bits", otdi, e.tdi);
                    chk("idle_pins", {TCK, TMS, TDI}, {1'b0, e.ltms, e.ltdi});
                    chk("resp_status", {BUSY, CMD_READY}, 2'b10);
                end
                for (int k = 0; k < e.hold; k++) begin
                    @(negedge CLK);
                    chk("rsp_hold", {RSP_VALID, CMD_READY, TCK, RSP_LEN, RSP_TDO},
                        {1'b1, 1'b0, 1'b0, 6'(e.len), e.tdo});
                end
                RSP_READY = 1'b1;
                last_hs   = cyc;
                @(negedge CLK);
                RSP_READY = 1'b0;
                chk("rsp_drop", {RSP_VALID, BUSY, CMD_READY}, 3'b001);
            end
        end
    end

    initial begin : driver
        int acc, n, len, div;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        chk("reset_ctrl", {CMD_READY, BUSY, RSP_VALID}, 3'b100);
        chk("reset_pins", {TCK, TMS, TDI}, 3'b000);
        chk("reset_rsp", {RSP_LEN, RSP_TDO}, 38'd0);

        // basic 5-bit shift, period 4
        send(5, 32'h1F, 32'h0A, 1, 1, $urandom, 1'b0, 1, 1'b1, acc);
        // full 32-bit loopback
        send(32, $urandom, 32'hA5A50F0F, 3, 3, '0, 1'b1, 0, 1'b1, acc);
        // zero length
        send(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 0, $urandom, 1'b0, 0, 1'b1, acc);
        // clamped length, fast TCK, long backpressure, queued follow-up
        send(40, $urandom, $urandom, 0, 0, $urandom, 1'b0, 10, 1'b1, acc);
        send(7, $urandom, $urandom, 0, 2, $urandom, 1'b0, 0, 1'b1, acc);
        chk("queue_gap", acc - last_hs, 2);
        // divider change mid-command, then a slow command
        send(6, $urandom, $urandom, 1, 7, $urandom, 1'b1, 0, 1'b1, acc);
        send(3, $urandom, $urandom, 7, 7, $urandom, 1'b0, 0, 1'b1, acc);

        // reset during bit 3 of an 8-bit command
        n = 0;
        while ((exp_q.size() != 0 || BUSY) && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        send(8, 32'hFF, 32'hFF, 1, 1, $urandom, 1'b0, 0, 1'b0, acc);
        n = 0;
        while (!((tck_total - cur_base) == 3 && TCK == 1'b0) && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        chk("reset_bit3_reached", {TMS, TDI}, 2'b11);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        chk("midreset_pins", {TCK, TMS, TDI}, 3'b000);
        chk("midreset_ctrl", {RSP_VALID, CMD_READY, BUSY}, 3'b010);
        model_tms = 1'b0;
        model_tdi = 1'b0;
        send(4, $urandom, $urandom, 1, 1, $urandom, 1'b0, 0, 1'b1, acc);

        // randomized commands
        for (int k = 0; k < 30; k++) begin
            len = $urandom_range(0, 40);
            div = $urandom_range(0, 3);
            send(len, $urandom, $urandom, div, $urandom_range(0, 255), $urandom,
                 1'($urandom), $urandom_range(0, 3), 1'b1, acc);
        end

        n = 0;
        while ((exp_q.size() != 0 || BUSY) && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (3) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
